lms_fir_serial: RTL and testbench

Parametrised N-tap adaptive FIR with LMS coefficient update. It is built around one time-shared multiplier, so area stays flat as tap count grows. It accepts one (x, d) sample pair per handshake, produces filter output y and error e = d − y, then optionally adapts all coefficients before accepting the next sample. It sits in the same signal-processing datapath as the fixed 3-tap adaptive filter and replaces it wherever tap count, step size or freeze/adapt control must vary.

---
 rtl/lms_fir_serial_pkg.sv | 19 +
 rtl/lms_fir_serial_mac.sv | 57 +++++
 rtl/lms_fir_serial.sv | 159 +++++++++++++++
 tb/tb_lms_fir_serial.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lms_fir_serial_pkg.sv
// Shared fixed-point format constants and FSM state encoding for the serial LMS FIR.
package lms_fir_serial_pkg;

    localparam int NB_DATA_DEF  = 32;
    localparam int NBF_DATA_DEF = 16;

    // Guard bits that keep an N-tap sum of Q(NB_DATA) products from wrapping.
    function automatic int acc_guard_bits(input int n_taps);
        return $clog2(n_taps);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILTER,
        ST_ERROR,
        ST_UPDATE
    } state_t;

endpackage

// File: rtl/lms_fir_serial_mac.sv
// Saturating truncation helper and the single time-shared multiplier of the LMS FIR.
module SatTruncFP #(
    parameter int NB_IN   = 64,
    parameter int NBF_IN  = 32,
    parameter int NB_OUT  = 32,
    parameter int NBF_OUT = 16
) (
    input  logic signed [NB_IN-1:0]  i_data,
    output logic signed [NB_OUT-1:0] o_data
);
    localparam int SHIFT = NBF_IN - NBF_OUT;

    logic signed [NB_IN-1:0] shifted;
    logic                    fits;

    // Arithmetic shift drops fraction bits, i.e. truncates toward minus infinity.
    assign shifted = i_data >>> SHIFT;
    assign fits    = (&shifted[NB_IN-1:NB_OUT-1]) | ~(|shifted[NB_IN-1:NB_OUT-1]);

    always_comb begin
        if (fits)
            o_data = shifted[NB_OUT-1:0];
        else if (shifted[NB_IN-1])
            o_data = {1'b1, {(NB_OUT-1){1'b0}}};
        else
            o_data = {1'b0, {(NB_OUT-1){1'b1}}};
    end
endmodule

module lms_mac_unit
    import lms_fir_serial_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int NBF_DATA = NBF_DATA_DEF
) (
    input  logic                      i_sel_update,
    input  logic signed [NB_DATA-1:0] i_h,
    input  logic signed [NB_DATA-1:0] i_e,
    input  logic signed [NB_DATA-1:0] i_x,
    output logic signed [NB_DATA-1:0] o_prod
);
    logic signed [NB_DATA-1:0]   coef_op;
    logic signed [2*NB_DATA-1:0] prod_full;

    assign coef_op   = i_sel_update ? i_e : i_h;
    assign prod_full = (2*NB_DATA)'(coef_op) * (2*NB_DATA)'(i_x);

    SatTruncFP #(
        .NB_IN  (2*NB_DATA),
        .NBF_IN (2*NBF_DATA),
        .NB_OUT (NB_DATA),
        .NBF_OUT(NBF_DATA)
    ) u_st (
        .i_data(prod_full),
        .o_data(o_prod)
    );
endmodule

// File: rtl/lms_fir_serial.sv
// N-tap adaptive FIR with LMS update, one multiply per cycle through lms_mac_unit.
module lms_fir_serial
    import lms_fir_serial_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int NBF_DATA = NBF_DATA_DEF,
    parameter int N_TAPS   = 8,
    parameter int MU_SHIFT = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    input  logic [NB_DATA-1:0]          i_x,
    input  logic [NB_DATA-1:0]          i_d,
    input  logic                        i_adapt,
    input  logic                        i_clear,
    input  logic [$clog2(N_TAPS)-1:0]   i_coef_addr,
    output logic                        o_ready,
    output logic                        o_valid,
    output logic [NB_DATA-1:0]          o_y,
    output logic [NB_DATA-1:0]          o_e,
    output logic [NB_DATA-1:0]          o_coef,
    output logic                        o_overrun
);
    localparam int            KW     = $clog2(N_TAPS);
    localparam int            NB_ACC = NB_DATA + acc_guard_bits(N_TAPS);
    localparam logic [KW-1:0] K_LAST = KW'(N_TAPS - 1);

    state_t                    state, state_nxt;
    logic [KW-1:0]             k;
    logic signed [NB_DATA-1:0] x_line [N_TAPS];
    logic signed [NB_DATA-1:0] h      [N_TAPS];
    logic signed [NB_DATA-1:0] d_reg, e_reg;
    logic                      adapt_reg;
    logic signed [NB_ACC-1:0]  acc;
    logic                      last_tap;
    logic signed [NB_DATA-1:0] prod_q, delta, y_sat, e_sat, h_new;
    logic signed [NB_DATA:0]   err_wide, h_sum;

    assign last_tap = (k == K_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid)
                    state_nxt = ST_FILTER;
            end
            ST_FILTER: if (last_tap) state_nxt = ST_ERROR;
            ST_ERROR:  state_nxt = adapt_reg ? ST_UPDATE : ST_IDLE;
            ST_UPDATE: if (last_tap) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    lms_mac_unit #(
        .NB_DATA (NB_DATA),
        .NBF_DATA(NBF_DATA)
    ) u_mac (
        .i_sel_update(state == ST_UPDATE),
        .i_h         (h[k]),
        .i_e         (e_reg),
        .i_x         (x_line[k]),
        .o_prod      (prod_q)
    );

    SatTruncFP #(
        .NB_IN(NB_ACC), .NBF_IN(NBF_DATA), .NB_OUT(NB_DATA), .NBF_OUT(NBF_DATA)
    ) u_sat_y (
        .i_data(acc),
        .o_data(y_sat)
    );

    assign err_wide = {d_reg[NB_DATA-1], d_reg} - {y_sat[NB_DATA-1], y_sat};

    SatTruncFP #(
        .NB_IN(NB_DATA + 1), .NBF_IN(NBF_DATA), .NB_OUT(NB_DATA), .NBF_OUT(NBF_DATA)
    ) u_sat_e (
        .i_data(err_wide),
        .o_data(e_sat)
    );

    assign delta = prod_q >>> MU_SHIFT;
    assign h_sum = {h[k][NB_DATA-1], h[k]} + {delta[NB_DATA-1], delta};

    SatTruncFP #(
        .NB_IN(NB_DATA + 1), .NBF_IN(NBF_DATA), .NB_OUT(NB_DATA), .NBF_OUT(NBF_DATA)
    ) u_sat_h (
        .i_data(h_sum),
        .o_data(h_new)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            k         <= '0;
            acc       <= '0;
            d_reg     <= '0;
            e_reg     <= '0;
            adapt_reg <= 1'b0;
            o_valid   <= 1'b0;
            o_y       <= '0;
            o_e       <= '0;
            o_coef    <= '0;
            o_overrun <= 1'b0;
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                x_line[i] <= '0;
                h[i]      <= '0;
            end
        end else begin
            o_valid <= 1'b0;
            o_coef  <= (int'(i_coef_addr) < N_TAPS) ? h[i_coef_addr] : '0;
            if (i_valid && state != ST_IDLE)
                o_overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    // Clear and acceptance may coincide: the sample is then filtered with h = 0.
                    if (i_clear)
                        for (int unsigned i = 0; i < N_TAPS; i++)
                            h[i] <= '0;
                    if (i_valid) begin
                        x_line[0] <= i_x;
                        for (int unsigned i = 1; i < N_TAPS; i++)
                            x_line[i] <= x_line[i-1];
                        d_reg     <= i_d;
                        adapt_reg <= i_adapt;
                        acc       <= '0;
                        k         <= '0;
                    end
                end
                ST_FILTER: begin
                    acc <= acc + NB_ACC'(prod_q);
                    k   <= last_tap ? '0 : k + KW'(1);
                end
                ST_ERROR: begin
                    o_y     <= y_sat;
                    o_e     <= e_sat;
                    e_reg   <= e_sat;
                    o_valid <= 1'b1;
                    k       <= '0;
                end
                ST_UPDATE: begin
                    h[k] <= h_new;
                    k    <= last_tap ? '0 : k + KW'(1);
                end
                default: k <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_lms_fir_serial.sv
// Directed and randomized bench for lms_fir_serial against an arithmetic LMS reference model.
module tb_lms_fir_serial;
    localparam int NT = 4;
    localparam int MU = 2;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, i_adapt, i_clear;
    logic [31:0] i_x, i_d;
    logic [1:0]  coef_addr;
    logic        o_ready, o_valid, o_overrun;
    logic [31:0] o_y, o_e, o_coef;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint mx [NT];
    longint mh [NT];
    longint exp_y, exp_e;
    logic [31:0] last_y, last_e;

    always #5 clk = ~clk;

    lms_fir_serial #(
        .NB_DATA (32),
        .NBF_DATA(16),
        .N_TAPS  (NT),
        .MU_SHIFT(MU)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_x        (i_x),
        .i_d        (i_d),
        .i_adapt    (i_adapt),
        .i_clear    (i_clear),
        .i_coef_addr(coef_addr),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_y        (o_y),
        .o_e        (o_e),
        .o_coef     (o_coef),
        .o_overrun  (o_overrun)
    );

    function automatic longint clamp(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Product of two Q16.16 values, floor to Q16.16, then clamp.
    function automatic longint st(input longint a, input longint b);
        longint p;
        p = a * b;
        return clamp(p >>> 16);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            mx[i] = 0;
            mh[i] = 0;
        end
    endtask

    task automatic model_sample(input int x, input int d, input bit adapt, input bit clear);
        longint acc;
        if (clear)
            for (int i = 0; i < NT; i++) mh[i] = 0;
        for (int i = NT - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = longint'(x);
        acc = 0;
        for (int i = 0; i < NT; i++) acc += st(mh[i], mx[i]);
        exp_y = clamp(acc);
        exp_e = clamp(longint'(d) - exp_y);
        if (adapt)
            for (int i = 0; i < NT; i++)
                mh[i] = clamp(mh[i] + (st(exp_e, mx[i]) >>> MU));
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        model_reset();
    endtask

    task automatic check_coefs(input string tag);
        for (int i = 0; i < NT; i++) begin
            @(negedge clk);
            coef_addr = 2'(i);
            @(negedge clk);
            check($sformatf("%s.h%0d", tag, i), o_coef, 32'(mh[i]));
        end
    endtask

    // ovr_cyc / rst_cyc: cycle (counted from acceptance) in which to pulse i_valid / i_rst; 0 = none.
    task automatic run_sample(input string tag, input int x, input int d, input bit adapt,
                              input bit clear, input int ovr_cyc, input int rst_cyc);
        int vcyc, rcyc, npulse;
        vcyc = -1; rcyc = -1; npulse = 0;
        @(negedge clk);
        check({tag, ".ready_in"}, {31'd0, o_ready}, 32'd1);
        i_valid = 1'b1; i_x = x; i_d = d; i_adapt = adapt; i_clear = clear;
        model_sample(x, d, adapt, clear);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            i_valid = (c == ovr_cyc);
            i_clear = (c == ovr_cyc);
            i_x     = (c == ovr_cyc) ? 32'h0003_0000 : x;
            i_rst   = (c == rst_cyc);
            if (rst_cyc > 0 && c == rst_cyc + 1) begin
                model_reset();
                check({tag, ".rst_ready"},   {31'd0, o_ready},   32'd1);
                check({tag, ".rst_valid"},   {31'd0, o_valid},   32'd0);
                check({tag, ".rst_overrun"}, {31'd0, o_overrun}, 32'd0);
                return;
            end
            if (o_valid) begin
                npulse++;
                if (vcyc < 0) vcyc = c;
                last_y = o_y;
                last_e = o_e;
            end
            if (o_ready) begin
                rcyc = c;
                break;
            end
        end
        check({tag, ".valid_cyc"}, 32'(vcyc), 32'(NT + 2));
        check({tag, ".ready_cyc"}, 32'(rcyc), adapt ? 32'(2 * NT + 2) : 32'(NT + 2));
        check({tag, ".npulse"},    32'(npulse), 32'd1);
        check({tag, ".y"},         last_y, 32'(exp_y));
        check({tag, ".e"},         last_e, 32'(exp_e));
    endtask

    initial begin
        longint prev_abs, cur_abs, hsum;
        bit     mono_ok;
        int     rx, rd;

        i_rst = 1'b1; i_valid = 1'b0; i_adapt = 1'b0; i_clear = 1'b0;
        i_x = '0; i_d = '0; coef_addr = '0;
        last_y = '0; last_e = '0;
        model_reset();
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        check("rst.ready",   {31'd0, o_ready},   32'd1);
        check("rst.valid",   {31'd0, o_valid},   32'd0);
        check("rst.y",       o_y,                32'd0);
        check("rst.e",       o_e,                32'd0);
        check("rst.coef",    o_coef,             32'd0);
        check("rst.overrun", {31'd0, o_overrun}, 32'd0);

        // Frozen coefficients: y = 0, e = d.
        run_sample("frozen", 32'h0001_0000, 32'h0000_8000, 1'b0, 1'b0, 0, 0);
        check("frozen.e_lit", last_e, 32'h0000_8000);
        check("frozen.y_lit", last_y, 32'h0000_0000);
        check_coefs("frozen");

        // One adaptation step from reset: h[0] = 0.125.
        do_reset();
        run_sample("adapt1", 32'h0001_0000, 32'h0000_8000, 1'b1, 1'b0, 0, 0);
        check("adapt1.e_lit", last_e, 32'h0000_8000);
        check_coefs("adapt1");
        coef_addr = 2'd0;
        repeat (2) @(negedge clk);
        check("adapt1.h0_lit", o_coef, 32'h0000_2000);

        // Convergence with x = 1.0, d = 0.5.
        mono_ok  = 1'b1;
        prev_abs = 64'sd2147483648;
        for (int n = 0; n < 200; n++) begin
            run_sample($sformatf("conv%0d", n), 32'h0001_0000, 32'h0000_8000, 1'b1, 1'b0, 0, 0);
            cur_abs = longint'($signed(last_e));
            if (cur_abs < 0) cur_abs = -cur_abs;
            if (cur_abs > prev_abs) mono_ok = 1'b0;
            prev_abs = cur_abs;
        end
        check("conv.monotonic", {31'd0, mono_ok}, 32'd1);
        check("conv.final_small", {31'd0, (prev_abs < 64'sd16)}, 32'd1);
        hsum = 0;
        for (int i = 0; i < NT; i++) begin
            @(negedge clk);
            coef_addr = 2'(i);
            @(negedge clk);
            hsum += longint'($signed(o_coef));
        end
        check("conv.hsum", {31'd0, (hsum >= 64'sd32768 - 2 * NT && hsum <= 64'sd32768 + 2 * NT)}, 32'd1);

        // Randomized samples, adapt and clear, against the reference model.
        for (int n = 0; n < 40; n++) begin
            rx = int'($urandom_range(0, 32'h0003_FFFF)) - 32'h0002_0000;
            rd = int'($urandom_range(0, 32'h0003_FFFF)) - 32'h0002_0000;
            run_sample($sformatf("rnd%0d", n), rx, rd, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 9) == 0), 0, 0);
            if (n % 10 == 9) check_coefs($sformatf("rnd%0d", n));
        end

        // Saturation: large h[0] times near-max x, most negative d.
        do_reset();
        run_sample("satpre", 32'h0001_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0, 0);
        run_sample("sat", 32'h7FFF_0000, 32'h8000_0000, 1'b0, 1'b0, 0, 0);
        check("sat.y_lit", last_y, 32'h7FFF_FFFF);
        check("sat.e_lit", last_e, 32'h8000_0000);

        // Overrun: dropped sample must not disturb results or the delay line.
        do_reset();
        run_sample("ovrA", 32'h0001_0000, 32'h0000_8000, 1'b1, 1'b0, 0, 0);
        run_sample("ovrB", 32'h0001_0000, 32'h0000_8000, 1'b1, 1'b0, 3, 0);
        check("ovr.flag", {31'd0, o_overrun}, 32'd1);
        check_coefs("ovr");
        run_sample("ovrC", 32'h0000_8000, 32'h0000_0000, 1'b0, 1'b0, 0, 0);
        check("ovr.sticky", {31'd0, o_overrun}, 32'd1);

        // Reset in cycle 7 (mid-UPDATE) aborts and clears everything.
        run_sample("midrst", 32'h0001_0000, 32'h0000_8000, 1'b1, 1'b0, 0, 7);
        check_coefs("midrst");
        run_sample("after", 32'h0001_0000, 32'h0000_8000, 1'b0, 1'b0, 0, 0);
        check("after.e_lit", last_e, 32'h0000_8000);
        check("after.y_lit", last_y, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
